// File: rtl/mem_stage_if.sv
// MEM stage bus: EX/MEM inputs from upstream and the MEM/WB outputs to writeback.
// The stage itself uses the slave modport; the driver of EX/MEM uses master.
interface mem_stage_if;
    logic [1:0]  WBin;
    logic [2:0]  Min;
    logic [31:0] ALUin;
    logic [31:0] WDin;
    logic [4:0]  Rdin;
    logic [1:0]  WBout;
    logic [31:0] RDout;
    logic [31:0] ALUout;
    logic [4:0]  Rdout;
    logic        stall;
    logic        align_err;

    modport master (
        output WBin, Min, ALUin, WDin, Rdin,
        input  WBout, RDout, ALUout, Rdout, stall, align_err
    );

    modport slave (
        input  WBin, Min, ALUin, WDin, Rdin,
        output WBout, RDout, ALUout, Rdout, stall, align_err
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory with a
// fixed multi-cycle access latency, upstream stall while busy, and the MEM/WB
// register. Misaligned accesses are dropped and flagged with a one-cycle pulse.
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    // Reload value for the wait counter; MEM_LAT = 0 never enters BUSY.
    localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [31:0]         mem [2**ADDR_W];

    logic                mem_read, mem_write, req, aligned;
    logic [ADDR_W-1:0]   idx;
    logic                stall_c, done, wr_en, align_n;
    logic [1:0]          wb_n;
    logic [31:0]         rd_n;
    logic                unused_bits;

    assign mem_read    = bus.Min[1];
    assign mem_write   = bus.Min[0];
    assign req         = mem_read | mem_write;
    assign aligned     = (bus.ALUin[1:0] == 2'b00);
    // Upper address bits are dropped so addresses wrap modulo the memory depth.
    assign idx         = bus.ALUin[ADDR_W+1:2];
    // Branch and the wrapped address bits are not consumed by this stage.
    assign unused_bits = ^{bus.Min[2], bus.ALUin[31:ADDR_W+2]};

    // Next-state, stall and MEM/WB next values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_c = 1'b0;
        done    = 1'b0;
        wr_en   = 1'b0;
        wb_n    = bus.WBin;
        rd_n    = 32'd0;
        align_n = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        wb_n    = 2'b00;
                        align_n = 1'b1;
                    end else if (MEM_LAT == 0) begin
                        done = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        wb_n    = 2'b00;
                        cnt_n   = LAT_M1;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    stall_c = 1'b1;
                    wb_n    = 2'b00;
                    cnt_n   = cnt - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Completion: write once, read returns the pre-write value; a combined
        // read+write performs the write and returns zero.
        if (done) begin
            wr_en = mem_write;
            if (mem_read && !mem_write)
                rd_n = mem[idx];
        end
    end

    assign bus.stall = stall_c & ~rst;

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // MEM/WB pipeline register; bubbles carry WBout = 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.WBout     <= 2'b00;
            bus.RDout     <= 32'd0;
            bus.ALUout    <= 32'd0;
            bus.Rdout     <= 5'd0;
            bus.align_err <= 1'b0;
        end else begin
            bus.WBout     <= wb_n;
            bus.RDout     <= rd_n;
            bus.ALUout    <= bus.ALUin;
            bus.Rdout     <= bus.Rdin;
            bus.align_err <= align_n;
        end
    end

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[idx] <= bus.WDin;
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with MEM_LAT=2 and one with
// MEM_LAT=0, sharing clock and reset.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mem_stage_if a ();
    mem_stage_if b ();

    mem_stage #(.ADDR_W(8), .MEM_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(a.slave));
    mem_stage #(.ADDR_W(8), .MEM_LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] rd);
        a.WBin = wb; a.Min = m; a.ALUin = alu; a.WDin = wd; a.Rdin = rd;
    endtask

    task automatic drive_b(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] rd);
        b.WBin = wb; b.Min = m; b.ALUin = alu; b.WDin = wd; b.Rdin = rd;
    endtask

    initial begin
        drive_a(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        drive_b(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        #1;
        check("rst_wbout", 32'(a.WBout), 32'd0);
        check("rst_align", 32'(a.align_err), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Plain ALU instruction passes through without stalling.
        drive_a(2'b10, 3'b000, 32'h1234, 32'd0, 5'd5);
        #1 check("alu_stall", 32'(a.stall), 32'd0);
        tick();
        check("alu_aluout", a.ALUout, 32'h1234);
        check("alu_rdout", 32'(a.Rdout), 32'd5);
        check("alu_wbout", 32'(a.WBout), 32'd2);
        check("alu_stall2", 32'(a.stall), 32'd0);

        // Async reset between edges, with an aligned load pending.
        drive_a(2'b11, 3'b010, 32'h40, 32'd0, 5'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_wbout", 32'(a.WBout), 32'd0);
        check("arst_aluout", a.ALUout, 32'd0);
        check("arst_rdout", 32'(a.Rdout), 32'd0);
        check("arst_stall", 32'(a.stall), 32'd0);
        tick();
        rst = 1'b0;
        drive_a(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        tick();

        // Store DEADBEEF @0x10: two stall cycles then completion.
        drive_a(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
        #1 check("st_stall0", 32'(a.stall), 32'd1);
        tick();
        check("st_stall1", 32'(a.stall), 32'd1);
        check("st_bubble", 32'(a.WBout), 32'd0);
        tick();
        check("st_stall2", 32'(a.stall), 32'd0);
        tick();

        // Load @0x10 into r8.
        drive_a(2'b11, 3'b010, 32'h10, 32'd0, 5'd8);
        #1 check("ld_stall0", 32'(a.stall), 32'd1);
        tick();
        check("ld_stall1", 32'(a.stall), 32'd1);
        check("ld_bubble", 32'(a.WBout), 32'd0);
        tick();
        check("ld_stall2", 32'(a.stall), 32'd0);
        check("ld_early", 32'(a.WBout), 32'd0);
        tick();
        check("ld_rdout", a.RDout, 32'hDEADBEEF);
        check("ld_wbout", 32'(a.WBout), 32'd3);
        check("ld_rd", 32'(a.Rdout), 32'd8);

        // Misaligned load @0x13: no stall, one-cycle align_err.
        drive_a(2'b11, 3'b010, 32'h13, 32'd0, 5'd9);
        #1 check("mis_stall", 32'(a.stall), 32'd0);
        tick();
        check("mis_err", 32'(a.align_err), 32'd1);
        check("mis_wbout", 32'(a.WBout), 32'd0);
        check("mis_rdout", a.RDout, 32'd0);
        check("mis_aluout", a.ALUout, 32'h13);
        drive_a(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        tick();
        check("mis_err_clr", 32'(a.align_err), 32'd0);

        // Seed 0x20 with zero.
        drive_a(2'b00, 3'b001, 32'h20, 32'd0, 5'd0);
        tick(); tick(); tick();
        // Store CAFE @0x20, abort with reset while BUSY.
        drive_a(2'b00, 3'b001, 32'h20, 32'h0000CAFE, 5'd0);
        tick();
        check("abort_busy", 32'(a.stall), 32'd1);
        #2 rst = 1'b1;
        #1 check("abort_stall", 32'(a.stall), 32'd0);
        tick(); tick();
        drive_a(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;
        tick();
        drive_a(2'b11, 3'b010, 32'h20, 32'd0, 5'd4);
        tick(); tick(); tick();
        check("abort_rd", a.RDout, 32'd0);
        check("abort_wb", 32'(a.WBout), 32'd3);

        // Read+write together: write happens, RDout is zero.
        drive_a(2'b10, 3'b011, 32'h30, 32'h77, 5'd6);
        tick(); tick(); tick();
        check("rw_rdout", a.RDout, 32'd0);
        drive_a(2'b11, 3'b010, 32'h30, 32'd0, 5'd6);
        tick(); tick(); tick();
        check("rw_readback", a.RDout, 32'h77);
        drive_a(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);

        // MEM_LAT=0: wrap-around and back-to-back accesses.
        drive_b(2'b00, 3'b001, 32'h400, 32'h55, 5'd0);
        #1 check("z_st_stall", 32'(b.stall), 32'd0);
        tick();
        drive_b(2'b11, 3'b010, 32'h000, 32'd0, 5'd3);
        #1 check("z_ld_stall", 32'(b.stall), 32'd0);
        tick();
        check("z_wrap_rd", b.RDout, 32'h55);
        check("z_wrap_wb", 32'(b.WBout), 32'd3);
        drive_b(2'b00, 3'b001, 32'h4, 32'h66, 5'd0);
        #1 check("z_st2_stall", 32'(b.stall), 32'd0);
        tick();
        check("z_st2_wb", 32'(b.WBout), 32'd0);
        drive_b(2'b11, 3'b010, 32'h4, 32'd0, 5'd7);
        tick();
        check("z_ld2_rd", b.RDout, 32'h66);
        check("z_ld2_rdout", 32'(b.Rdout), 32'd7);
        drive_b(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
